mem_requester: RTL and testbench

Initiator side of the 16-bit byte-enabled memory bus: accepts one load/store at a time from the datapath, drives `read`/`write`/`byte_enable`/`address`/`wdata` to the memory responder, and holds them stable until `resp`. It returns read data with byte-lane extraction and optional sign extension. It also flags misaligned word accesses and responder timeouts. Sits between the datapath/MDR logic and the memory, one instance per port (fetch, load/store).

---
 rtl/mem_req_pkg.sv | 10 +
 rtl/mem_lane_align.sv | 21 ++
 rtl/mem_requester.sv | 90 +++++++++
 tb/tb_mem_requester.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared state encoding, lane-enable constants and counter sizing for mem_requester.
package mem_req_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic        addr0,
  input  logic        byte_acc,
  input  logic        sign_ext,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  byte_enable,
  output logic [15:0] aligned_wdata,
  output logic [15:0] load_data
);
  logic [7:0] lane;
  always_comb begin
    byte_enable = byte_acc ? (addr0 ? BE_HI : BE_LO) : BE_WORD;
    aligned_wdata = byte_acc ? {2{wdata[7:0]}} : wdata;
    lane = addr0 ? rdata[15:8] : rdata[7:0];
    load_data = byte_acc ? {{8{sign_ext & lane[7]}}, lane} : rdata;
  end
endmodule

// File: rtl/mem_requester.sv
// mem_requester: single-outstanding initiator for the 16-bit byte-enabled memory bus.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [15:0] rsp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic lat_write, lat_byte, lat_signed, lat_addr0;
  logic sel_addr0, sel_byte, misaligned, timeout;
  logic [1:0] be;
  logic [15:0] al_wdata, ld_data;
  // One aligner serves both directions: store steering only matters while
  // accepting in IDLE, load extraction only while waiting in ACCESS.
  mem_lane_align u_align (
    .addr0        (sel_addr0),
    .byte_acc     (sel_byte),
    .sign_ext     (lat_signed),
    .wdata        (req_wdata),
    .rdata        (mem_rdata),
    .byte_enable  (be),
    .aligned_wdata(al_wdata),
    .load_data    (ld_data)
  );
  always_comb begin
    req_ready = state == IDLE;
    misaligned = !req_byte && req_addr[0];
    timeout = cnt + CW'(1) == CW'(TIMEOUT_CYCLES);
    sel_addr0 = req_ready ? req_addr[0] : lat_addr0;
    sel_byte = req_ready ? req_byte : lat_byte;
    state_n = state == IDLE ? (req_valid ? (misaligned ? RESPOND : ACCESS) : IDLE)
            : state == ACCESS ? ((mem_resp || timeout) ? RESPOND : ACCESS)
            : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      {lat_write, lat_byte, lat_signed, lat_addr0} <= '0;
      {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} <= '0;
      {rsp_valid, rsp_error, rsp_rdata} <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        {lat_write, lat_byte, lat_signed, lat_addr0} <= {req_write, req_byte, req_signed, req_addr[0]};
        cnt <= '0;
        if (misaligned) begin
          {rsp_valid, rsp_error, rsp_rdata} <= {2'b11, 16'h0};
        end else begin
          mem_read <= !req_write;
          mem_write <= req_write;
          mem_address <= {req_addr[15:1], 1'b0};
          mem_byte_enable <= be;
          mem_wdata <= al_wdata;
        end
      end
      if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
        // A response arriving on the timeout edge takes priority over the abort.
        if (mem_resp || timeout) begin
          {mem_read, mem_write} <= 2'b00;
          rsp_valid <= 1'b1;
          rsp_error <= !mem_resp;
          rsp_rdata <= (mem_resp && !lat_write) ? ld_data : 16'h0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: randomized and directed checks of mem_requester against a transaction-level model.
module tb_mem_requester;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata, rsp_rdata, mem_address, mem_wdata, mem_rdata;
  logic rsp_valid, rsp_error, mem_read, mem_write, mem_resp;
  logic [1:0] mem_byte_enable;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_error(rsp_error), .rsp_rdata(rsp_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata)
  );

  // delay = ACCESS cycle on which the responder answers; 0 means it never answers.
  task automatic run_txn(input string name, input logic w, b, s, input logic [15:0] a, wd,
                         input int delay, input logic [15:0] rd);
    logic mis, to, err;
    logic [7:0] lane;
    logic [15:0] exp_rd;
    logic [35:0] exp_bus;
    int exp_cyc;
    mis = !b && a[0];
    to = !mis && (delay == 0 || delay > TO);
    err = mis || to;
    exp_cyc = mis ? 0 : to ? TO : delay;
    lane = a[0] ? rd[15:8] : rd[7:0];
    exp_rd = (err || w) ? 16'h0 : !b ? rd : (s && lane >= 8'd128) ? 16'(int'(lane) - 256) : 16'(lane);
    exp_bus = {!w, w, b ? (a[0] ? 2'b10 : 2'b01) : 2'b11, a & 16'hFFFE, b ? {2{wd[7:0]}} : wd};
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", name, req_ready);
    end
    {req_valid, req_write, req_byte, req_signed, req_addr, req_wdata} = {1'b1, w, b, s, a, wd};
    @(negedge clk);
    for (int k = 1; k <= exp_cyc; k++) begin
      {req_valid, req_write, req_byte, req_signed} = 4'($urandom);
      req_addr = 16'($urandom);
      req_wdata = 16'($urandom);
      mem_resp = (k == delay);
      mem_rdata = (k == delay) ? rd : 16'($urandom);
      n_cmp++;
      if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, rsp_valid, req_ready} !== {exp_bus, 2'b00}) begin
        n_fail++;
        $display("FAIL %s bus_cycle%0d: got rd%b wr%b be%b a%h wd%h v%b rdy%b want %h/00", name, k,
                 mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, rsp_valid, req_ready, exp_bus);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_resp = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_error, rsp_rdata, mem_read, mem_write, req_ready} !== {1'b1, err, exp_rd, 3'b000}) begin
      n_fail++;
      $display("FAIL %s respond: got v%b e%b d%h rd%b wr%b rdy%b want v1 e%b d%h strobes0 rdy0", name,
               rsp_valid, rsp_error, rsp_rdata, mem_read, mem_write, req_ready, err, exp_rd);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_error, rsp_rdata, mem_read, mem_write, req_ready} !== {1'b0, err, exp_rd, 3'b001}) begin
      n_fail++;
      $display("FAIL %s idle_after: got v%b e%b d%h rd%b wr%b rdy%b want v0 e%b d%h strobes0 rdy1", name,
               rsp_valid, rsp_error, rsp_rdata, mem_read, mem_write, req_ready, err, exp_rd);
    end
  endtask

  task automatic test_reset;
    {req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_resp, mem_rdata} = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, rsp_valid, rsp_error, rsp_rdata, req_ready} !== 55'h1) begin
      n_fail++;
      $display("FAIL reset: got rd%b wr%b be%b a%h wd%h v%b e%b d%h rdy%b want all 0 rdy1", mem_read, mem_write,
               mem_byte_enable, mem_address, mem_wdata, rsp_valid, rsp_error, rsp_rdata, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_load;
    run_txn("word_load", 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1234, 5, 16'hBEEF);
  endtask

  task automatic test_byte_store;
    run_txn("byte_store", 1'b1, 1'b1, 1'b0, 16'h2001, 16'h00A5, 3, 16'h5555);
  endtask

  task automatic test_byte_load_ext;
    run_txn("byte_load_signed", 1'b0, 1'b1, 1'b1, 16'h3001, 16'h0, 2, 16'h80FF);
    run_txn("byte_load_unsigned", 1'b0, 1'b1, 1'b0, 16'h3001, 16'h0, 2, 16'h80FF);
    run_txn("byte_load_lo_signed", 1'b0, 1'b1, 1'b1, 16'h3000, 16'h0, 1, 16'h12F0);
  endtask

  task automatic test_misaligned;
    run_txn("misaligned_store", 1'b1, 1'b0, 1'b0, 16'h4003, 16'hCAFE, 0, 16'h0);
  endtask

  task automatic test_timeout;
    run_txn("timeout_silent", 1'b0, 1'b0, 1'b0, 16'h6000, 16'h0, 0, 16'h0);
    run_txn("resp_on_limit", 1'b0, 1'b0, 1'b0, 16'h6002, 16'h0, TO, 16'h7E57);
  endtask

  task automatic test_spurious_resp;
    for (int k = 0; k < 3; k++) begin
      mem_resp = 1'b1;
      mem_rdata = 16'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, mem_read, mem_write, req_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL spurious_resp: got v%b rd%b wr%b rdy%b want 0 0 0 1", rsp_valid, mem_read, mem_write, req_ready);
      end
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset_mid;
    {req_valid, req_write, req_byte, req_signed, req_addr, req_wdata} = {4'b1000, 16'h5000, 16'h0};
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, rsp_valid, rsp_error, rsp_rdata, req_ready} !== 55'h1) begin
      n_fail++;
      $display("FAIL reset_mid: got rd%b wr%b be%b a%h wd%h v%b e%b d%h rdy%b want all 0 rdy1", mem_read, mem_write,
               mem_byte_enable, mem_address, mem_wdata, rsp_valid, rsp_error, rsp_rdata, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_rsp: got %b want 0", rsp_valid);
    end
    run_txn("after_reset", 1'b0, 1'b0, 1'b0, 16'h5000, 16'h0, 4, 16'hA1B2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_txn("random", 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 10)), 16'($urandom));
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_byte_store;
    test_byte_load_ext;
    test_misaligned;
    test_timeout;
    test_spurious_resp;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
